// File: rtl/tank_video_pkg.sv
// Shared types and constants for the tank game video path.
package tank_video_pkg;

    localparam int COLOR_W = 12;
    localparam int COORD_W = 10;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [COORD_W-1:0] coord_t;

    // Colour key the sprite ROMs use for "no pixel here".
    localparam color_t TRANSPARENT = 12'h00f;

    // Bit positions inside the collision flag vector.
    localparam int COL_T0_WALL = 0;
    localparam int COL_T1_WALL = 1;
    localparam int COL_BUL_T0  = 2;
    localparam int COL_BUL_T1  = 3;
    localparam int COL_T0_T1   = 4;
    localparam int COL_W       = 5;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with a uniform reset value in every stage.
module delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per clock; every stage returns to RESET_VAL on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/layer_mixer.sv
// Final pixel mixer: fixed layer priority, sync alignment and per-frame
// collision flags for game logic.
//
// Stream timing (no handshake, one pixel per clock, never stalls):
// x/y/video_on/hsync/vsync enter at cycle t, the layer inputs describing that
// same pixel arrive at t+BG_LATENCY, and rgb plus all delayed sync outputs
// leave together on the edge at t+BG_LATENCY+1.
module layer_mixer
    import tank_video_pkg::*;
#(
    parameter int     BG_LATENCY  = 2,
    parameter int     H_ACTIVE    = 640,
    parameter int     V_ACTIVE    = 480,
    parameter logic   SYNC_IDLE   = 1'b1,
    parameter color_t BLANK_COLOR = 12'h000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             video_on,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             bg_on,
    input  logic             bg_wall,
    input  logic [11:0]      bg_color,
    input  logic             tank0_on,
    input  logic [11:0]      tank0_color,
    input  logic             tank1_on,
    input  logic [11:0]      tank1_color,
    input  logic             bullet_on,
    input  logic [11:0]      bullet_color,
    output logic [11:0]      rgb,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             video_on_out,
    output logic [COL_W-1:0] collision,
    output logic             frame_done
);

    localparam int             BUS_W    = 2 * COORD_W + 3;
    localparam logic [BUS_W-1:0] BUS_RST = {{(2 * COORD_W){1'b0}}, 1'b0, SYNC_IDLE, SYNC_IDLE};
    localparam coord_t         H_LIM    = coord_t'(H_ACTIVE);
    localparam coord_t         V_LIM    = coord_t'(V_ACTIVE);

    logic [BUS_W-1:0] w_bus_in;
    logic [BUS_W-1:0] w_bus_d;
    coord_t           w_dx;
    coord_t           w_dy;
    logic             w_dvid;
    logic             w_dhs;
    logic             w_dvs;
    logic             w_in_area;
    logic             w_tick;
    color_t           w_pix;
    logic [COL_W-1:0] w_hits;

    logic [COL_W-1:0] r_acc;

    assign w_bus_in = {x, y, video_on, hsync, vsync};

    delay_line #(
        .WIDTH     (BUS_W),
        .DEPTH     (BG_LATENCY),
        .RESET_VAL (BUS_RST)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_bus_in),
        .o_q   (w_bus_d)
    );

    assign {w_dx, w_dy, w_dvid, w_dhs, w_dvs} = w_bus_d;

    // video_on already excludes off-screen coordinates; the range test only
    // guards against a sync generator that raises video_on too early.
    assign w_in_area = w_dvid && (w_dx < H_LIM) && (w_dy < V_LIM);

    // Level-qualified tick: first pixel of the first blank line.
    assign w_tick = (w_dx == '0) && (w_dy == V_LIM);

    // Pick the topmost opaque layer; blanking wins over every layer.
    always_comb begin
        w_pix = BLANK_COLOR;
        if (w_dvid) begin
            if (bullet_on) begin
                w_pix = bullet_color;
            end else if (tank0_on) begin
                w_pix = tank0_color;
            end else if (tank1_on) begin
                w_pix = tank1_color;
            end else if (bg_on) begin
                w_pix = bg_color;
            end
        end
    end

    // Overlap detection for the current pixel, visible area only.
    always_comb begin
        w_hits = '0;
        if (w_in_area) begin
            w_hits[COL_T0_WALL] = tank0_on  & bg_wall;
            w_hits[COL_T1_WALL] = tank1_on  & bg_wall;
            w_hits[COL_BUL_T0]  = bullet_on & tank0_on;
            w_hits[COL_BUL_T1]  = bullet_on & tank1_on;
            w_hits[COL_T0_T1]   = tank0_on  & tank1_on;
        end
    end

    // Output register: colour and delayed syncs change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb          <= BLANK_COLOR;
            hsync_out    <= SYNC_IDLE;
            vsync_out    <= SYNC_IDLE;
            video_on_out <= 1'b0;
        end else begin
            rgb          <= w_pix;
            hsync_out    <= w_dhs;
            vsync_out    <= w_dvs;
            video_on_out <= w_dvid;
        end
    end

    // Sticky per-frame accumulator, published and cleared on the frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            collision  <= '0;
            frame_done <= 1'b0;
        end else if (w_tick) begin
            collision  <= r_acc | w_hits;
            r_acc      <= '0;
            frame_done <= 1'b1;
        end else begin
            r_acc      <= r_acc | w_hits;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: driver pushes expected output words into a
// queue, a negedge monitor pops and compares every output cycle.
module tb_layer_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on, hsync, vsync;
    logic        bg_on, bg_wall, tank0_on, tank1_on, bullet_on;
    logic [11:0] bg_color, tank0_color, tank1_color, bullet_color;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, video_on_out, frame_done;
    logic [4:0]  collision;

    // Output word layout: {rgb, hsync_out, vsync_out, video_on_out, frame_done, collision}
    localparam int W = 21;

    logic [W-1:0] exp_q[$];
    int           due_q[$];

    int           cyc     = 0;
    int           n_total = 0;
    int           n_pass  = 0;

    logic [4:0]   lay_d1;
    logic [4:0]   lay_d2;
    logic [4:0]   exp_col;

    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    layer_mixer dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .video_on     (video_on),
        .hsync        (hsync),
        .vsync        (vsync),
        .bg_on        (bg_on),
        .bg_wall      (bg_wall),
        .bg_color     (bg_color),
        .tank0_on     (tank0_on),
        .tank0_color  (tank0_color),
        .tank1_on     (tank1_on),
        .tank1_color  (tank1_color),
        .bullet_on    (bullet_on),
        .bullet_color (bullet_color),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out),
        .collision    (collision),
        .frame_done   (frame_done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    // lay bits: {bullet, tank0, tank1, bg_on, bg_wall}
    task automatic apply_layers(input logic [4:0] l);
        {bullet_on, tank0_on, tank1_on, bg_on, bg_wall} = l;
    endtask

    task automatic push_exp(input logic [W-1:0] v, input int due);
        exp_q.push_back(v);
        due_q.push_back(due);
    endtask

    // One pixel: coordinates now, its layer data two cycles later.
    task automatic px(input logic [9:0] px_x, input logic [9:0] px_y,
                      input logic vid, input logic hs, input logic vs,
                      input logic [4:0] lay, input logic [11:0] exp_rgb);
        logic fd;
        @(posedge clk);
        #1;
        x        = px_x;
        y        = px_y;
        video_on = vid;
        hsync    = hs;
        vsync    = vs;
        apply_layers(lay_d2);
        lay_d2 = lay_d1;
        lay_d1 = lay;
        fd = (px_x == 10'd0) && (px_y == 10'd480);
        push_exp({exp_rgb, hs, vs, vid, fd, exp_col}, cyc + 3);
    endtask

    task automatic tick(input logic [4:0] col_after);
        exp_col = col_after;
        px(10'd0, 10'd480, 1'b0, 1'b1, 1'b0, 5'b00000, 12'h000);
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) px(10'd700 + 10'(i), 10'd20, 1'b0, 1'b1, 1'b1, 5'b00000, 12'h000);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [W-1:0] act;
        logic [W-1:0] want;
        act  = {rgb, hsync_out, vsync_out, video_on_out, frame_done, collision};
        want = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        n_total++;
        if (act !== want)
            $display("FAIL %s: got rgb=%h hs=%b vs=%b vid=%b fd=%b col=%b, want rgb=%h hs=%b vs=%b vid=%b fd=%b col=%b",
                     name, act[20:9], act[8], act[7], act[6], act[5], act[4:0],
                     want[20:9], want[8], want[7], want[6], want[5], want[4:0]);
        else
            n_pass++;
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        x        = '0;
        y        = '0;
        video_on = 1'b0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        lay_d1   = '0;
        lay_d2   = '0;
        apply_layers(5'b00000);
        exp_col  = '0;
        #1;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
    endtask

    // Release: the three edges after release still show pipeline reset values.
    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++)
            push_exp({12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000}, cyc + i);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s: %0d outputs still pending, want 0", name, exp_q.size());
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        while (exp_q.size() != 0 && due_q[0] <= cyc) begin
            mon_exp = exp_q.pop_front();
            void'(due_q.pop_front());
            mon_act = {rgb, hsync_out, vsync_out, video_on_out, frame_done, collision};
            n_total++;
            if (mon_act !== mon_exp)
                $display("FAIL out_cmp cyc=%0d: got rgb=%h hs=%b vs=%b vid=%b fd=%b col=%b, want rgb=%h hs=%b vs=%b vid=%b fd=%b col=%b",
                         cyc, mon_act[20:9], mon_act[8], mon_act[7], mon_act[6], mon_act[5], mon_act[4:0],
                         mon_exp[20:9], mon_exp[8], mon_exp[7], mon_exp[6], mon_exp[5], mon_exp[4:0]);
            else
                n_pass++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset        = 1'b1;
        x            = '0;
        y            = '0;
        video_on     = 1'b0;
        hsync        = 1'b1;
        vsync        = 1'b1;
        bullet_color = 12'hF00;
        tank0_color  = 12'h0F0;
        tank1_color  = 12'h00F;
        bg_color     = 12'h888;
        lay_d1       = '0;
        lay_d2       = '0;
        exp_col      = '0;
        apply_layers(5'b00000);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");

        // Release with video_on=1, hsync=0: hsync_out low appears 3 edges later.
        release_reset();
        px(10'd0,  10'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 12'h000);

        // Priority ladder.
        px(10'd10, 10'd5, 1'b1, 1'b1, 1'b1, 5'b11110, 12'hF00);
        px(10'd11, 10'd5, 1'b1, 1'b1, 1'b1, 5'b01110, 12'h0F0);
        px(10'd12, 10'd5, 1'b1, 1'b1, 1'b1, 5'b00110, 12'h00F);
        px(10'd13, 10'd5, 1'b1, 1'b1, 1'b1, 5'b00010, 12'h888);
        px(10'd14, 10'd5, 1'b1, 1'b1, 1'b1, 5'b00000, 12'h000);

        // Blanking hides everything and records no hits.
        px(10'd20, 10'd5, 1'b0, 1'b1, 1'b1, 5'b11111, 12'h000);

        // Overlaps from the priority ladder: bullet/tank0, bullet/tank1, tank0/tank1.
        tick(5'b11100);
        px(10'd1, 10'd480, 1'b0, 1'b1, 1'b1, 5'b00000, 12'h000);

        // Frame: tank0 on wall once, bullet over tank1 three times.
        px(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 5'b01011, 12'h0F0);
        px(10'd101, 10'd100, 1'b1, 1'b1, 1'b1, 5'b10100, 12'hF00);
        px(10'd102, 10'd100, 1'b1, 1'b1, 1'b1, 5'b10100, 12'hF00);
        px(10'd103, 10'd100, 1'b1, 1'b1, 1'b1, 5'b10100, 12'hF00);
        tick(5'b01001);

        // Frame with no overlaps.
        px(10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 5'b00010, 12'h888);
        px(10'd201, 10'd200, 1'b1, 1'b1, 1'b1, 5'b00100, 12'h00F);
        px(10'd202, 10'd200, 1'b1, 1'b1, 1'b1, 5'b00011, 12'h888);
        tick(5'b00000);

        // Tanks overlapping outside the visible area must not count.
        px(10'd650, 10'd10,  1'b0, 1'b0, 1'b1, 5'b01100, 12'h000);
        px(10'd700, 10'd490, 1'b0, 1'b1, 1'b0, 5'b01100, 12'h000);
        px(10'd0,   10'd481, 1'b0, 1'b1, 1'b1, 5'b01100, 12'h000);
        tick(5'b00000);

        // Tank1 hits a wall, then reset mid-frame wipes that hit.
        px(10'd50, 10'd50, 1'b1, 1'b1, 1'b1, 5'b00111, 12'h00F);
        idle3();
        wait_drain("drain_before_reset");
        assert_reset();
        release_reset();
        px(10'd60, 10'd60, 1'b1, 1'b1, 1'b1, 5'b01011, 12'h0F0);
        px(10'd61, 10'd60, 1'b1, 1'b1, 1'b1, 5'b00000, 12'h000);
        tick(5'b00001);
        px(10'd1, 10'd480, 1'b0, 1'b1, 1'b1, 5'b00000, 12'h000);
        px(10'd5, 10'd5,   1'b1, 1'b1, 1'b1, 5'b00010, 12'h888);
        tick(5'b00000);

        idle3();
        wait_drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Downstream of background_engine and the sprite engines (tank0, tank1, bullet); feeds the VGA output pins.
- Selects the final pixel colour by fixed layer priority.
- Delays sync and position signals so they line up with the layer data.
- Accumulates per-frame collision flags, which game logic reads once per frame.

Parameters:
BG_LATENCY, 2, cycles from x/y/video_on/sync input to arrival of matching layer data (bg_*, tank*, bullet*)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SYNC_IDLE, 1, level driven on hsync_out/vsync_out during reset (active-low VGA sync)
BLANK_COLOR, 12'h000, colour when no layer is on or video is blanked

Ports:
clk  in  1  system pixel clock
reset  in  1  asynchronous, active-high reset
x  in  10  current pixel column from sync generator
y  in  10  current pixel row from sync generator
video_on  in  1  visible-region flag, aligned with x/y
hsync  in  1  horizontal sync, aligned with x/y
vsync  in  1  vertical sync, aligned with x/y
bg_on  in  1  background pixel opaque (BG_LATENCY after x/y)
bg_wall  in  1  background pixel belongs to a wall tile
bg_color  in  12  background RGB444
tank0_on  in  1  tank0 sprite pixel opaque
tank0_color  in  12  tank0 RGB444
tank1_on  in  1  tank1 sprite pixel opaque
tank1_color  in  12  tank1 RGB444
bullet_on  in  1  bullet sprite pixel opaque
bullet_color  in  12  bullet RGB444
rgb  out  12  final pixel colour
hsync_out  out  1  hsync delayed to match rgb
vsync_out  out  1  vsync delayed to match rgb
video_on_out  out  1  video_on delayed to match rgb
collision  out  5  latched collision flags of previous frame
frame_done  out  1  one-cycle pulse when collision updates

Behaviour:
- Reset is asynchronous and active-high: asserting reset immediately forces the listed reset values; deassertion is sampled on the clk rising edge.
- Reset values:
  - rgb = BLANK_COLOR
  - hsync_out = vsync_out = SYNC_IDLE
  - video_on_out = 0
  - collision = 0
  - frame_done = 0
  - all delay-line stages: video_on = 0, sync = SYNC_IDLE, x = y = 0
  - collision accumulator = 0
- Alignment: x, y, video_on, hsync, vsync pass through a BG_LATENCY-deep delay line. Their delayed copies (dx, dy, dvid, dhs, dvs) are valid in the same cycle as the layer inputs.
- Output stage is one register. Total latency from x/y input to rgb/sync out = BG_LATENCY+1 cycles. Sync, video_on_out and rgb always change on the same edge.
- Colour priority, evaluated with dvid=1:
  1. bullet
  2. tank0
  3. tank1
  4. background (bg_on)
  5. otherwise BLANK_COLOR
- dvid=0 -> rgb = BLANK_COLOR regardless of layer inputs.
- Collision bits, accumulated sticky (OR) only when dvid=1:
  - [0] tank0_on & bg_wall
  - [1] tank1_on & bg_wall
  - [2] bullet_on & tank0_on
  - [3] bullet_on & tank1_on
  - [4] tank0_on & tank1_on
- Frame tick: the cycle where dx==0 and dy==V_ACTIVE (first blank line after the visible area). At the next edge:
  - collision <= accumulator OR'd with the current-cycle hits (current hits are zero, since dvid=0 on the tick)
  - accumulator cleared
  - frame_done = 1 for exactly one cycle
- collision holds its value between ticks.
- Ticks are edge-independent: if dy holds V_ACTIVE with dx==0 for only one cycle per frame, exactly one tick occurs per frame.
- Reset mid-frame: the accumulator is cleared. The first tick after reset reports only hits from the partial frame. No spurious frame_done fires while the delay line refills.
- x/y outside H_ACTIVE/V_ACTIVE never accumulate, because video_on gates them.
- No arithmetic; widths are fixed at 12-bit colour and 10-bit coordinates.

Decomposition:
- Shared package tank_video_pkg:
  - COLOR_W = 12
  - typedef color_t (logic [11:0])
  - TRANSPARENT = 12'h00f
  - localparams COL_T0_WALL = 0, COL_T1_WALL = 1, COL_BUL_T0 = 2, COL_BUL_T1 = 3, COL_T0_T1 = 4
  - typedef coord_t (logic [9:0])
- Sub-module delay_line: parameters WIDTH, DEPTH, RESET_VAL; async active-high reset. Instantiated once for a packed {x, y, video_on, hsync, vsync} bus with DEPTH = BG_LATENCY.

Test Plan:
- Reset held, then released with video_on=1, hsync=0 applied: the first BG_LATENCY+1 output edges show hsync_out = 1 and rgb = 000; hsync_out = 0 appears exactly BG_LATENCY+1 cycles after the input.
- Layer priority with dvid=1 and all inputs on (bullet=F00, tank0=0F0, tank1=00F, bg=888): rgb = F00. Drop bullet -> 0F0. Drop tank0 -> 00F. Drop tank1 -> 888. Drop bg -> 000.
- Blanking: all layers on, video_on=0 -> rgb = 000, video_on_out = 0.
- Collision: during one frame, tank0_on & bg_wall for 1 pixel and bullet_on & tank1_on for 3 pixels. At the frame tick, frame_done pulses for 1 cycle and collision = 5'b01001. Next frame with no overlaps -> collision = 5'b00000.
- Collision outside the visible area: tank0_on = tank1_on = 1 with video_on = 0 throughout -> collision[4] stays 0 after the tick.
- Reset asserted mid-frame after tank1 hits a wall, then released: at the next tick, collision[1] = 0 and exactly one frame_done pulse occurs per frame.
